// File: rtl/game_state_ctrl_pkg.sv
// Shared game State encodings and widths, imported by this controller and every State consumer.
package game_state_ctrl_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned TIME_W  = 10;

   // SPAUSE sits on the encoding consumers already treat as their default case.
   typedef enum logic [STATE_W-1:0] {
      SMENU  = 2'd0,
      SGAME  = 2'd1,
      SOVER  = 2'd2,
      SPAUSE = 2'd3
   } game_state_e;

endpackage

// File: rtl/btn_conditioner.sv
// One push-button path: 2-FF synchronizer, debounce counter and rising-edge one-pulse.
module btn_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             prev_q, prev_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = cnt_q;
      prev_d  = level_q;
      press_d = level_q & ~prev_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         level_d = ~level_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         prev_q  <= prev_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Menu/game/over controller with button conditioning and per-game countdown.
// Define GAME_PAUSE_EN to add btn_pause and the SPAUSE state.
module game_state_ctrl
   import game_state_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 20,
   parameter int unsigned TICK_LEN        = 100000000,
   parameter int unsigned GAME_TIME_S     = 600
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_start,
   input  logic               btn_reset,
`ifdef GAME_PAUSE_EN
   input  logic               btn_pause,
`endif
   input  logic               board_solved,
   output logic [STATE_W-1:0] State,
   output logic [TIME_W-1:0]  time_left,
   output logic               win,
   output logic               start_pulse
);

   localparam int unsigned PRE_W = (TICK_LEN > 1) ? $clog2(TICK_LEN) : 1;

   logic start_level, start_press;
   logic reset_level, reset_press;
   logic pause_press;
   logic unused_levels;

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
      .clk(clk), .rst(rst), .btn_raw(btn_start), .level(start_level), .press(start_press)
   );

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset (
      .clk(clk), .rst(rst), .btn_raw(btn_reset), .level(reset_level), .press(reset_press)
   );

`ifdef GAME_PAUSE_EN
   logic pause_level;

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
      .clk(clk), .rst(rst), .btn_raw(btn_pause), .level(pause_level), .press(pause_press)
   );

   assign unused_levels = start_level ^ reset_level ^ pause_level;
`else
   assign pause_press   = 1'b0;
   assign unused_levels = start_level ^ reset_level;
`endif

   game_state_e       state_q, state_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [TIME_W-1:0] time_q, time_d;
   logic              win_q, win_d;
   logic              sp_q, sp_d;
   logic              tick_c;

   // Abort press beats everything; in a game, a solve beats the final tick for win.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      time_d  = time_q;
      win_d   = win_q;
      sp_d    = 1'b0;
      tick_c  = (pre_q == PRE_W'(TICK_LEN - 1));
      if (reset_press) begin
         state_d = SMENU;
      end else begin
         case (state_q)
            SMENU: begin
               if (start_press) begin
                  state_d = SGAME;
                  time_d  = TIME_W'(GAME_TIME_S);
                  pre_d   = '0;
                  win_d   = 1'b0;
                  sp_d    = 1'b1;
               end
            end
            SGAME: begin
               if (pause_press) begin
                  state_d = SPAUSE;
               end else begin
                  pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
                  if (tick_c && (time_q != '0)) begin
                     time_d = time_q - TIME_W'(1);
                  end
                  if (board_solved) begin
                     state_d = SOVER;
                     win_d   = 1'b1;
                  end else if (tick_c && (time_q == TIME_W'(1))) begin
                     state_d = SOVER;
                     win_d   = 1'b0;
                  end
               end
            end
            SOVER: begin
               if (start_press) begin
                  state_d = SMENU;
               end
            end
`ifdef GAME_PAUSE_EN
            SPAUSE: begin
               if (pause_press) begin
                  state_d = SGAME;
               end
            end
`endif
            default: state_d = SMENU;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SMENU;
         pre_q   <= '0;
         time_q  <= '0;
         win_q   <= 1'b0;
         sp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         time_q  <= time_d;
         win_q   <= win_d;
         sp_q    <= sp_d;
      end
   end

   assign State       = state_q;
   assign time_left   = time_q;
   assign win         = win_q;
   assign start_pulse = sp_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomized self-checking bench for game_state_ctrl against a behavioural model.
// Build with GAME_PAUSE_EN defined to exercise the pause feature as well.
module tb_game_state_ctrl;

   localparam int DEB = 4;
   localparam int TL  = 10;
   localparam int GT  = 3;
`ifdef GAME_PAUSE_EN
   localparam bit PAUSE = 1'b1;
`else
   localparam bit PAUSE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_start = 1'b0;
   logic       btn_reset = 1'b0;
`ifdef GAME_PAUSE_EN
   logic       btn_pause = 1'b0;
`endif
   logic       board_solved = 1'b0;
   logic [1:0] State;
   logic [9:0] time_left;
   logic       win;
   logic       start_pulse;
   logic [13:0] obs_vec;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   game_state_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_LEN(TL), .GAME_TIME_S(GT)) dut (
      .clk(clk),
      .rst(rst),
      .btn_start(btn_start),
      .btn_reset(btn_reset),
`ifdef GAME_PAUSE_EN
      .btn_pause(btn_pause),
`endif
      .board_solved(board_solved),
      .State(State),
      .time_left(time_left),
      .win(win),
      .start_pulse(start_pulse)
   );

   assign obs_vec = {State, time_left, win, start_pulse};

   // ---------------- behavioural reference model ----------------
   // Buttons: sample seen at an edge is the raw level from two edges earlier;
   // the level flips once the last DEB samples all disagree with it.
   bit rawh   [3][2];
   bit samp   [3][DEB];
   bit m_lvl  [3];
   bit m_rose [3];
   bit m_press[3];
   int m_state, m_time, m_win, m_sp, m_pre;

   function automatic bit raw_in(input int b);
      case (b)
         0: return btn_start;
         1: return btn_reset;
`ifdef GAME_PAUSE_EN
         2: return btn_pause;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [13:0] exp_vec();
      return {2'(m_state), 10'(m_time), 1'(m_win), 1'(m_sp)};
   endfunction

   always @(posedge clk) begin : ref_model
      bit p[3];
      bit s, flip, tick, solved;
      for (int b = 0; b < 3; b++) p[b] = m_press[b];
      solved = board_solved;
      if (rst) begin
         for (int b = 0; b < 3; b++) begin
            rawh[b][0] = 0; rawh[b][1] = 0;
            for (int i = 0; i < DEB; i++) samp[b][i] = 0;
            m_lvl[b] = 0; m_rose[b] = 0; m_press[b] = 0;
         end
         m_state = 0; m_time = 0; m_win = 0; m_sp = 0; m_pre = 0;
      end else begin
         for (int b = 0; b < 3; b++) begin
            s = rawh[b][1];
            rawh[b][1] = rawh[b][0];
            rawh[b][0] = raw_in(b);
            m_press[b] = m_rose[b];
            m_rose[b]  = 0;
            for (int i = DEB - 1; i > 0; i--) samp[b][i] = samp[b][i-1];
            samp[b][0] = s;
            flip = 1;
            for (int i = 0; i < DEB; i++) if (samp[b][i] == m_lvl[b]) flip = 0;
            if (flip) begin
               m_rose[b] = !m_lvl[b];
               m_lvl[b]  = !m_lvl[b];
            end
         end
         m_sp = 0;
         if (p[1]) m_state = 0;
         else begin
            case (m_state)
               0: if (p[0]) begin
                     m_state = 1; m_time = GT; m_pre = 0; m_win = 0; m_sp = 1;
                  end
               1: if (PAUSE && p[2]) m_state = 3;
                  else begin
                     tick  = (m_pre == TL - 1);
                     m_pre = (m_pre + 1) % TL;
                     if (tick && m_time == 1) begin
                        m_time = 0; m_state = 2; m_win = 0;
                     end else if (tick && m_time > 0) m_time = m_time - 1;
                     if (solved) begin m_state = 2; m_win = 1; end
                  end
               2: if (p[0]) m_state = 0;
               3: if (p[2]) m_state = 1;
               default: m_state = 0;
            endcase
         end
      end
   end

   // ---------------- stimulus helper (no checking) ----------------
   task automatic fresh_game(output bit ok);
      ok = 0;
      btn_reset = 1;
      repeat (DEB + 3) @(negedge clk);
      btn_reset = 0;
      repeat (DEB + 6 + $urandom_range(0, 3)) @(negedge clk);
      btn_start = 1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (start_pulse) ok = 1;
         if (i == DEB + 3) btn_start = 0;
      end
      btn_start = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [13:0] e;
      rst = 1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (obs_vec !== 14'd0) begin
         n_fail++; $display("FAIL reset_values: got %h want %h", obs_vec, 14'd0);
      end
      e = exp_vec();
      n_checks++;
      if (obs_vec !== e) begin
         n_fail++; $display("FAIL reset_model: got %h want %h", obs_vec, e);
      end
      rst = 0;
   endtask

   task automatic test_start_debounce();
      logic [13:0] e;
      int pulses = 0;
      bit ph = 1'($urandom_range(0, 1));
      for (int i = 0; i < 22; i++) begin
         if (i < 6) btn_start = ph ^ i[0];
         else if (i < 12) btn_start = 1;
         else btn_start = 0;
         @(negedge clk);
         pulses += int'(start_pulse);
         e = exp_vec();
         n_checks++;
         if (obs_vec !== e) begin
            n_fail++; $display("FAIL debounce_model cyc %0d: got %h want %h", i, obs_vec, e);
         end
      end
      n_checks++;
      if (pulses != 1) begin
         n_fail++; $display("FAIL debounce_pulse_count: got %0d want 1", pulses);
      end
      n_checks++;
      if ({State, time_left} !== {2'd1, 10'(GT)}) begin
         n_fail++; $display("FAIL debounce_game: got State=%0d time_left=%0d want 1 %0d", State, time_left, GT);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int et, es;
      logic [13:0] e;
      fresh_game(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL timeout_start: got no start_pulse want 1"); end
      for (int j = 1; j <= 32; j++) begin
         @(negedge clk);
         et = (j >= 30) ? 0 : GT - j / 10;
         es = (j >= 30) ? 2 : 1;
         n_checks++;
         if ({State, time_left, win} !== {2'(es), 10'(et), 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_seq j=%0d: got State=%0d time_left=%0d win=%0b want %0d %0d 0", j, State, time_left, win, es, et);
         end
         e = exp_vec();
         n_checks++;
         if (obs_vec !== e) begin
            n_fail++; $display("FAIL timeout_model j=%0d: got %h want %h", j, obs_vec, e);
         end
      end
   endtask

   task automatic test_solve_on_final_tick();
      bit ok;
      logic [13:0] e;
      fresh_game(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL solve_start: got no start_pulse want 1"); end
      for (int j = 1; j <= 31; j++) begin
         @(negedge clk);
         e = exp_vec();
         n_checks++;
         if (obs_vec !== e) begin
            n_fail++; $display("FAIL solve_model j=%0d: got %h want %h", j, obs_vec, e);
         end
         if (j == 30) begin
            n_checks++;
            if ({State, time_left, win} !== {2'd2, 10'd0, 1'b1}) begin
               n_fail++;
               $display("FAIL solve_final_tick: got State=%0d time_left=%0d win=%0b want 2 0 1", State, time_left, win);
            end
         end
         board_solved = (j == 29);
      end
      board_solved = 0;
   endtask

   task automatic test_start_and_abort();
      bit ok;
      int sp = 0;
      logic [13:0] e;
      fresh_game(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL abort_start: got no start_pulse want 1"); end
      repeat ($urandom_range(8, 14)) @(negedge clk);
      btn_start = 1; btn_reset = 1;
      for (int i = 0; i < 26; i++) begin
         if (i == 16) begin btn_start = 0; btn_reset = 0; end
         @(negedge clk);
         sp += int'(start_pulse);
         e = exp_vec();
         n_checks++;
         if (obs_vec !== e) begin
            n_fail++; $display("FAIL abort_model cyc %0d: got %h want %h", i, obs_vec, e);
         end
      end
      n_checks++;
      if (State !== 2'd0 || sp != 0) begin
         n_fail++; $display("FAIL abort_state: got State=%0d pulses=%0d want 0 0", State, sp);
      end
   endtask

   task automatic test_over_restart();
      bit ok, got;
      logic [13:0] e;
      fresh_game(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL over_start: got no start_pulse want 1"); end
      repeat (2) @(negedge clk);
      board_solved = 1;
      @(negedge clk);
      board_solved = 0;
      n_checks++;
      if ({State, time_left, win} !== {2'd2, 10'(GT), 1'b1}) begin
         n_fail++; $display("FAIL over_solved: got State=%0d time_left=%0d win=%0b want 2 %0d 1", State, time_left, win, GT);
      end
      for (int i = 0; i < 30; i++) begin
         btn_start = (i >= 10 && i < 18);
         @(negedge clk);
         e = exp_vec();
         n_checks++;
         if (obs_vec !== e) begin
            n_fail++; $display("FAIL over_model cyc %0d: got %h want %h", i, obs_vec, e);
         end
      end
      n_checks++;
      if ({State, time_left, win} !== {2'd0, 10'(GT), 1'b1}) begin
         n_fail++; $display("FAIL over_to_menu: got State=%0d time_left=%0d win=%0b want 0 %0d 1", State, time_left, win, GT);
      end
      btn_start = 1;
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (start_pulse) got = 1;
         if (i == 8) btn_start = 0;
      end
      btn_start = 0;
      n_checks++;
      if (!got || {State, time_left, win} !== {2'd1, 10'(GT), 1'b0}) begin
         n_fail++;
         $display("FAIL over_restart: got pulse=%0b State=%0d time_left=%0d win=%0b want 1 1 %0d 0", got, State, time_left, win, GT);
      end
   endtask

`ifdef GAME_PAUSE_EN
   task automatic test_pause();
      bit ok;
      int es, et;
      logic [13:0] e;
      fresh_game(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL pause_start: got no start_pulse want 1"); end
      for (int j = 1; j <= 82; j++) begin
         @(negedge clk);
         e = exp_vec();
         n_checks++;
         if (obs_vec !== e) begin
            n_fail++; $display("FAIL pause_model j=%0d: got %h want %h", j, obs_vec, e);
         end
         if (j >= 17) begin
            es = (j >= 17 && j < 75) ? 3 : 1;
            et = (j >= 79) ? 1 : 2;
            n_checks++;
            if ({State, time_left} !== {2'(es), 10'(et)}) begin
               n_fail++; $display("FAIL pause_seq j=%0d: got State=%0d time_left=%0d want %0d %0d", j, State, time_left, es, et);
            end
         end
         btn_pause = (j >= 9 && j < 21) || (j >= 67 && j < 72);
      end
      btn_pause = 0;
   endtask
`endif

   task automatic test_rst_midgame();
      bit ok;
      logic [13:0] e;
      fresh_game(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rst_mid_start: got no start_pulse want 1"); end
      repeat (12) @(negedge clk);
      btn_start = 1; rst = 1;
      @(negedge clk);
      n_checks++;
      if (obs_vec !== 14'd0) begin
         n_fail++; $display("FAIL rst_midgame: got %h want %h", obs_vec, 14'd0);
      end
      e = exp_vec();
      n_checks++;
      if (obs_vec !== e) begin
         n_fail++; $display("FAIL rst_mid_model: got %h want %h", obs_vec, e);
      end
      rst = 0; btn_start = 0;
   endtask

   task automatic test_random();
      int run[3];
      int thr[3];
      bit val[3];
      logic [13:0] e;
      thr = '{5, 1, 3};
      for (int b = 0; b < 3; b++) begin run[b] = 0; val[b] = 0; end
      for (int c = 0; c < 800; c++) begin
         for (int b = 0; b < 3; b++) begin
            run[b]--;
            if (run[b] <= 0) begin
               val[b] = ($urandom_range(0, 9) < thr[b]);
               run[b] = $urandom_range(1, 10);
            end
         end
         btn_start = val[0];
         btn_reset = val[1];
`ifdef GAME_PAUSE_EN
         btn_pause = val[2];
`endif
         board_solved = ($urandom_range(0, 59) == 0);
         @(negedge clk);
         e = exp_vec();
         n_checks++;
         if (obs_vec !== e) begin
            n_fail++; $display("FAIL random_model cyc %0d: got %h want %h", c, obs_vec, e);
         end
      end
      btn_start = 0; btn_reset = 0; board_solved = 0;
`ifdef GAME_PAUSE_EN
      btn_pause = 0;
`endif
   endtask

   initial begin
      test_reset();
      test_start_debounce();
      test_timeout();
      test_solve_on_final_tick();
      test_start_and_abort();
      test_over_restart();
`ifdef GAME_PAUSE_EN
      test_pause();
`endif
      test_rst_midgame();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
